// File: rtl/adder_bist.sv
// Built-in self-test engine for a combinational WIDTH-bit ripple adder.
// It sweeps every operand pair, checks sum/carry/overflow against a golden result and records the first failure.
module adder_bist #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic [WIDTH-1:0]   a,
   output logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   sum,
   input  logic               carryout,
   input  logic               overflow,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   error_count,
   output logic               fail_valid,
   output logic [WIDTH-1:0]   fail_a,
   output logic [WIDTH-1:0]   fail_b
);

   localparam int IW = 2 * WIDTH;
   localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
   localparam logic [IW:0]   ERR_ONE  = {{IW{1'b0}}, 1'b1};
   localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW:0]       err_q, err_d;
   logic              fv_q, fv_d;
   logic [WIDTH-1:0]  fa_q, fa_d;
   logic [WIDTH-1:0]  fb_q, fb_d;

   logic [WIDTH:0]    exp_full;
   logic              exp_ovf;
   logic              mismatch;

   assign a = idx_q[IW-1:WIDTH];
   assign b = idx_q[WIDTH-1:0];

   // Golden result is taken from the registered operands, the same values the adder sees.
   always_comb begin
      exp_full = {1'b0, a} + {1'b0, b};
      exp_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (exp_full[WIDTH-1] != a[WIDTH-1]);
      mismatch = (sum != exp_full[WIDTH-1:0]) || (carryout != exp_full[WIDTH]) ||
                 (overflow != exp_ovf);
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fv_d    = fv_q;
      fa_d    = fa_q;
      fb_d    = fb_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_SETTLE;
               idx_d   = '0;
               cnt_d   = '0;
               err_d   = '0;
               fv_d    = 1'b0;
               fa_d    = '0;
               fb_d    = '0;
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_CHECK;
               cnt_d   = '0;
            end
         end
         S_CHECK: begin
            if (mismatch) begin
               err_d = err_q + ERR_ONE;
               if (!fv_q) begin
                  fv_d = 1'b1;
                  fa_d = a;
                  fb_d = b;
               end
            end
            // Operands advance only here, so the adder inputs stay stable through each settle window.
            if (idx_q == '1) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IDX_ONE;
               cnt_d   = '0;
               state_d = S_SETTLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         fv_q    <= 1'b0;
         fa_q    <= '0;
         fb_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
         fa_q    <= fa_d;
         fb_q    <= fb_d;
      end
   end

   assign busy        = (state_q == S_SETTLE) || (state_q == S_CHECK);
   assign done        = (state_q == S_DONE);
   assign pass        = done && (err_q == '0);
   assign error_count = err_q;
   assign fail_valid  = fv_q;
   assign fail_a      = fa_q;
   assign fail_b      = fb_q;

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: a behavioural adder with injectable faults drives the BIST,
// and a scoreboard of expected operand pairs checks the sweep order and final report.
module tb_adder_bist;

   logic       clk = 1'b0;
   logic       reset, start;
   logic [3:0] a, b, sum;
   logic       carryout, overflow, busy, done, pass, fail_valid;
   logic [8:0] error_count;
   logic [3:0] fail_a, fail_b;
   logic [1:0] fault;

   logic       start2;
   logic [1:0] a2, b2, sum2;
   logic       co2, ov2, busy2, done2, pass2, fv2;
   logic [4:0] ec2;
   logic [1:0] fa2, fb2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   adder_bist #(.WIDTH(4), .SETTLE(2)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .sum(sum),
      .carryout(carryout), .overflow(overflow), .busy(busy), .done(done), .pass(pass),
      .error_count(error_count), .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b));

   adder_bist #(.WIDTH(2), .SETTLE(1)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .sum(sum2),
      .carryout(co2), .overflow(ov2), .busy(busy2), .done(done2), .pass(pass2),
      .error_count(ec2), .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2));

   // Adder under test: fault 0 ideal, 1 sum[0] stuck 0, 2 carry stuck 0, 3 overflow inverted.
   always_comb begin
      logic [4:0] t;
      t        = {1'b0, a} + {1'b0, b};
      sum      = t[3:0];
      carryout = t[4];
      overflow = (a[3] == b[3]) && (t[3] != a[3]);
      case (fault)
         2'd1:    sum[0]   = 1'b0;
         2'd2:    carryout = 1'b0;
         2'd3:    overflow = ~overflow;
         default: ;
      endcase
   end

   always_comb begin
      logic [2:0] t2;
      t2   = {1'b0, a2} + {1'b0, b2};
      sum2 = t2[1:0];
      co2  = t2[2];
      ov2  = (a2[1] == b2[1]) && (t2[1] != a2[1]);
   end

   typedef struct {
      logic [1:0] fault;
      logic       extra;
      int         err;
      logic       pass;
      logic       fv;
      int         fa;
      int         fb;
   } vec_t;

   typedef struct {
      int a;
      int b;
   } pair_t;

   vec_t  tbl[6];
   pair_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_row(input vec_t v, input int row);
      pair_t cur;
      cur = '{0, 0};
      fault = v.fault;
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 256; i++) sb.push_back('{i / 16, i % 16});
      for (int j = 0; j < 768; j++) begin
         @(negedge clk);
         if (j % 3 == 0) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else cur = sb.pop_front();
         end
         chk($sformatf("r%0d_a", row), a, cur.a);
         chk($sformatf("r%0d_b", row), b, cur.b);
         chk($sformatf("r%0d_busy", row), busy, 1);
         chk($sformatf("r%0d_done_early", row), done, 0);
         start = (v.extra && j == 50) ? 1'b1 : 1'b0;
      end
      @(negedge clk);
      chk($sformatf("r%0d_sb_empty", row), sb.size(), 0);
      chk($sformatf("r%0d_done", row), done, 1);
      chk($sformatf("r%0d_busy_end", row), busy, 0);
      chk($sformatf("r%0d_err", row), error_count, v.err);
      chk($sformatf("r%0d_pass", row), pass, v.pass);
      chk($sformatf("r%0d_fv", row), fail_valid, v.fv);
      chk($sformatf("r%0d_fa", row), fail_a, v.fa);
      chk($sformatf("r%0d_fb", row), fail_b, v.fb);
      sb.delete();
   endtask

   initial begin
      tbl[0] = '{2'd0, 1'b0,   0, 1'b1, 1'b0, 0,  0};
      tbl[1] = '{2'd1, 1'b0, 128, 1'b0, 1'b1, 0,  1};
      tbl[2] = '{2'd2, 1'b0, 120, 1'b0, 1'b1, 1, 15};
      tbl[3] = '{2'd3, 1'b0, 256, 1'b0, 1'b1, 0,  0};
      tbl[4] = '{2'd0, 1'b0,   0, 1'b1, 1'b0, 0,  0};
      tbl[5] = '{2'd0, 1'b1,   0, 1'b1, 1'b0, 0,  0};

      reset  = 1'b1;
      start  = 1'b0;
      start2 = 1'b0;
      fault  = 2'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", error_count, 0);
      chk("rst_fv", fail_valid, 0);
      chk("rst_ab", {a, b}, 0);

      for (int r = 0; r < 6; r++) run_row(tbl[r], r);

      // Reset mid-sweep with overflow inverted: every compared pair has been counted.
      fault = 2'd3;
      @(negedge clk);
      start = 1'b1;
      for (int j = 0; j < 100; j++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("mid_err", error_count, 33);
      chk("mid_fv", fail_valid, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_pass", pass, 0);
      chk("mrst_err", error_count, 0);
      chk("mrst_fv", fail_valid, 0);
      chk("mrst_fab", {fail_a, fail_b}, 0);
      chk("mrst_ab", {a, b}, 0);
      @(negedge clk);
      chk("mrst_idle", busy, 0);
      chk("mrst_ab_hold", {a, b}, 0);
      fault = 2'd0;

      // Small configuration: WIDTH=2, SETTLE=1, each pair held two cycles.
      @(negedge clk);
      start2 = 1'b1;
      for (int j = 0; j < 32; j++) begin
         @(negedge clk);
         start2 = 1'b0;
         chk("w2_a", a2, (j / 2) / 4);
         chk("w2_b", b2, (j / 2) % 4);
         chk("w2_busy", busy2, 1);
      end
      @(negedge clk);
      chk("w2_done", done2, 1);
      chk("w2_pass", pass2, 1);
      chk("w2_err", ec2, 0);
      chk("w2_fv", fv2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
